hc595_chain_ctrl: RTL and testbench

- Parametrised serial driver for a cascade of 74HC595 shift registers (segment/select, LED or relay chains).
- Accepts a DATA_W-bit word via a valid/ready handshake and shifts it out on ds/shcp with a configurable bit period. It then pulses stcp to latch the word and reports completion.
- Sits between display/scan logic and board pins. It replaces fixed-width, free-running shifting with on-demand transfers.

---
 rtl/hc595_pkg.sv | 13 +
 rtl/hc595_bit_timer.sv | 43 ++++
 rtl/hc595_chain_ctrl.sv | 157 +++++++++++++++
 tb/tb_hc595_chain_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 cascade driver.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int HC595_DIV_MIN = 2;
  localparam int HC595_PWM_W   = 8;

endpackage

// File: rtl/hc595_bit_timer.sv
// Bit-period phase counter; phase_zero/phase_half look ahead to the phase after the next edge,
// bit_end flags the current cycle as the last of its bit period.
module hc595_bit_timer
  import hc595_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase_zero,
  output logic phase_half,
  output logic bit_end
);

  localparam int DIV_EFF = (DIV < HC595_DIV_MIN) ? HC595_DIV_MIN : DIV;
  localparam int PW      = (DIV_EFF > 2) ? $clog2(DIV_EFF) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV_EFF - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(DIV_EFF / 2);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (en) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Registered users line their outputs up with the phase that becomes current.
  assign phase_zero = (phase_d == '0);
  assign phase_half = (phase_d == PH_HALF);
  assign bit_end    = (phase_q == PH_LAST);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// On-demand serial driver for a 74HC595 cascade: shift DATA_W bits on ds/shcp, pulse stcp, report done.
// Optional HC595_PWM_EN adds a bright input that dims the chain through oe_n.
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ds,
  output logic              shcp,
  output logic              stcp,
  output logic              oe_n,
  output logic              done
`ifdef HC595_PWM_EN
  ,
  input  logic [HC595_PWM_W-1:0] bright
`endif
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sreg_q, sreg_d, sreg_shift;
  logic              ds_q, ds_d;
  logic              shcp_q, shcp_d;
  logic              stcp_q, stcp_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              oe_n_q, oe_n_d;
  logic              seen_q, seen_d;
  logic              tmr_en, phase_zero, phase_half, bit_end, wrap;

  assign tmr_en = (state_q != IDLE);
  assign wrap   = tmr_en && bit_end;

  hc595_bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .en         (tmr_en),
    .phase_zero (phase_zero),
    .phase_half (phase_half),
    .bit_end    (bit_end)
  );

  assign sreg_shift = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    ds_d    = ds_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          state_d = SHIFT;
          bit_d   = '0;
          sreg_d  = in_data;
          ds_d    = (MSB_FIRST != 0) ? in_data[DATA_W-1] : in_data[0];
        end
      end
      SHIFT: begin
        if (wrap) begin
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
            bit_d   = '0;
          end else begin
            bit_d  = bit_q + BW'(1);
            sreg_d = sreg_shift;
            ds_d   = (MSB_FIRST != 0) ? sreg_shift[DATA_W-1] : sreg_shift[0];
          end
        end
      end
      LATCH: begin
        if (wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clocks rise at the half-bit phase and fall at phase zero of the upcoming cycle.
  always_comb begin
    shcp_d = 1'b0;
    stcp_d = 1'b0;
    if (state_d == SHIFT) begin
      shcp_d = phase_half ? 1'b1 : (phase_zero ? 1'b0 : shcp_q);
    end
    if (state_d == LATCH) begin
      stcp_d = phase_half ? 1'b1 : (phase_zero ? 1'b0 : stcp_q);
    end
    ready_d = (state_d == IDLE);
    seen_d  = seen_q | done_d;
  end

`ifdef HC595_PWM_EN
  logic [HC595_PWM_W-1:0] pwm_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + HC595_PWM_W'(1);
    end
  end

  assign oe_n_d = !seen_d || (pwm_q >= bright);
`else
  assign oe_n_d = !seen_d;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sreg_q  <= '0;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      oe_n_q  <= 1'b1;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      oe_n_q  <= oe_n_d;
      seen_q  <= seen_d;
    end
  end

  assign in_ready = ready_q;
  assign ds       = ds_q;
  assign shcp     = shcp_q;
  assign stcp     = stcp_q;
  assign oe_n     = oe_n_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Bench for hc595_chain_ctrl: instance 0 is MSB-first DIV=4, instance 1 is LSB-first DIV=2.
module tb_hc595_chain_ctrl;

  localparam int DATA_W = 14;
  localparam int DIV_A  = 4;
  localparam int DIV_B  = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [DATA_W-1:0] in_data [2];
  logic [1:0] in_valid;
  logic [1:0] in_ready, ds, shcp, stcp, oe_n, done;
`ifdef HC595_PWM_EN
  logic [7:0] bright;
`endif

  hc595_chain_ctrl #(.DATA_W(DATA_W), .DIV(DIV_A), .MSB_FIRST(1)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ds(ds[0]), .shcp(shcp[0]), .stcp(stcp[0]), .oe_n(oe_n[0]), .done(done[0])
`ifdef HC595_PWM_EN
    , .bright(bright)
`endif
  );

  hc595_chain_ctrl #(.DATA_W(DATA_W), .DIV(DIV_B), .MSB_FIRST(0)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ds(ds[1]), .shcp(shcp[1]), .stcp(stcp[1]), .oe_n(oe_n[1]), .done(done[1])
`ifdef HC595_PWM_EN
    , .bright(bright)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Scoreboard: accepted words and the cycle their done pulse must land in.
  logic [DATA_W-1:0] word_q0[$], word_q1[$];
  int done_q0[$], done_q1[$];

  int rise_cnt[2], last_rise[2], hi_run[2], st_run[2], st_pulses[2];
  int st_rise[2], st_rise_prev[2], done_cnt[2];
  bit seen[2], p_shcp[2], p_stcp[2], p_done[2];

  function automatic int divof(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic bit exp_bit(input logic [DATA_W-1:0] w, input int k, input bit msb);
    return msb ? w[DATA_W-1-k] : w[k];
  endfunction

  task automatic note_accept(input int i);
    int lat;
    lat = DATA_W * divof(i) + divof(i) + 1;
    if (i == 0) begin
      word_q0.push_back(in_data[0]);
      done_q0.push_back(cyc + lat);
    end else begin
      word_q1.push_back(in_data[1]);
      done_q1.push_back(cyc + lat);
    end
  endtask

  always @(negedge sys_clk) begin : mon
    logic [DATA_W-1:0] w;
    int exp_cyc;
    bit have;
    bit eb;
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst_n) begin
        rise_cnt[i] = 0; hi_run[i] = 0; st_run[i] = 0; seen[i] = 1'b0;
        p_shcp[i] = 1'b0; p_stcp[i] = 1'b0; p_done[i] = 1'b0;
      end else begin
        if (shcp[i] && !p_shcp[i]) begin
          have = (i == 0) ? (word_q0.size() > 0) : (word_q1.size() > 0);
          w    = !have ? '0 : ((i == 0) ? word_q0[0] : word_q1[0]);
          eb   = (rise_cnt[i] < DATA_W) ? exp_bit(w, rise_cnt[i], i == 0) : 1'b0;
          vectors++;
          if (!have || rise_cnt[i] >= DATA_W || ds[i] !== eb) begin
            miscompares++;
            $display("FAIL ds_at_shcp_rise inst%0d bit%0d: got %b, want %b (word pending %0d)",
                     i, rise_cnt[i], ds[i], eb, have);
          end
          if (rise_cnt[i] > 0) begin
            vectors++;
            if (cyc - last_rise[i] != divof(i)) begin
              miscompares++;
              $display("FAIL shcp_period inst%0d: got %0d, want %0d", i, cyc - last_rise[i], divof(i));
            end
          end
          vectors++;
          if (in_ready[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL in_ready_busy inst%0d: got %b, want 0", i, in_ready[i]);
          end
          last_rise[i] = cyc;
          rise_cnt[i]++;
        end
        if (shcp[i]) hi_run[i]++;
        else if (p_shcp[i]) begin
          vectors++;
          if (hi_run[i] != divof(i) / 2) begin
            miscompares++;
            $display("FAIL shcp_high_width inst%0d: got %0d, want %0d", i, hi_run[i], divof(i) / 2);
          end
          hi_run[i] = 0;
        end
        if (stcp[i] && !p_stcp[i]) begin
          st_rise_prev[i] = st_rise[i];
          st_rise[i] = cyc;
        end
        if (stcp[i]) st_run[i]++;
        else if (p_stcp[i]) begin
          vectors++;
          if (st_run[i] != divof(i) / 2 || done[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL stcp_width inst%0d: got width %0d done %b, want width %0d done 1",
                     i, st_run[i], done[i], divof(i) / 2);
          end
          st_pulses[i]++;
          st_run[i] = 0;
        end
        if (done[i]) begin
          vectors++;
          if (p_done[i]) begin
            miscompares++;
            $display("FAIL done_one_cycle inst%0d: got 2+ cycle pulse, want 1", i);
          end
          seen[i] = 1'b1;
          done_cnt[i]++;
          have    = (i == 0) ? (done_q0.size() > 0) : (done_q1.size() > 0);
          exp_cyc = !have ? -1 : ((i == 0) ? done_q0[0] : done_q1[0]);
          vectors++;
          if (!have || cyc != exp_cyc) begin
            miscompares++;
            $display("FAIL done_cycle inst%0d: got cycle %0d, want %0d", i, cyc, exp_cyc);
          end
          vectors++;
          if (rise_cnt[i] != DATA_W) begin
            miscompares++;
            $display("FAIL shcp_rise_count inst%0d: got %0d, want %0d", i, rise_cnt[i], DATA_W);
          end
          if (have) begin
            if (i == 0) begin void'(word_q0.pop_front()); void'(done_q0.pop_front()); end
            else begin void'(word_q1.pop_front()); void'(done_q1.pop_front()); end
          end
          rise_cnt[i] = 0;
        end
`ifdef HC595_PWM_EN
        if (!seen[i]) begin
`else
        begin
`endif
          vectors++;
          if (oe_n[i] !== !seen[i]) begin
            miscompares++;
            $display("FAIL oe_n inst%0d cycle %0d: got %b, want %b", i, cyc, oe_n[i], !seen[i]);
          end
        end
        p_shcp[i] = shcp[i];
        p_stcp[i] = stcp[i];
        p_done[i] = done[i];
      end
    end
  end

  task automatic accept_word(input int i, input logic [DATA_W-1:0] w);
    bit got;
    got = 1'b0;
    @(posedge sys_clk); #1;
    in_data[i]  = w;
    in_valid[i] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge sys_clk);
      if (in_ready[i]) begin
        note_accept(i);
        got = 1'b1;
        break;
      end
    end
    @(posedge sys_clk); #1;
    in_valid[i] = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL accept_timeout inst%0d: got no handshake, want one", i);
    end
  endtask

  task automatic wait_dones(input int i, input int start, input int n);
    int k;
    for (k = 0; k < 1000 && done_cnt[i] < start + n; k++) @(negedge sys_clk);
    @(negedge sys_clk);
    vectors++;
    if (done_cnt[i] < start + n) begin
      miscompares++;
      $display("FAIL done_timeout inst%0d: got %0d dones, want %0d", i, done_cnt[i] - start, n);
    end
  endtask

  task automatic test_reset;
    in_valid   = 2'b00;
    in_data[0] = '0;
    in_data[1] = '0;
`ifdef HC595_PWM_EN
    bright = 8'd128;
`endif
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({in_ready[i], ds[i], shcp[i], stcp[i], oe_n[i], done[i]} !== 6'b100010) begin
        miscompares++;
        $display("FAIL reset_values inst%0d: got rdy,ds,shcp,stcp,oe_n,done=%b, want 100010", i,
                 {in_ready[i], ds[i], shcp[i], stcp[i], oe_n[i], done[i]});
      end
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({in_ready[i], oe_n[i]} !== 2'b11) begin
        miscompares++;
        $display("FAIL after_release inst%0d: got rdy,oe_n=%b, want 11", i, {in_ready[i], oe_n[i]});
      end
    end
  endtask

  task automatic test_single_word;
    int p0, d0;
    p0 = st_pulses[0];
    d0 = done_cnt[0];
    accept_word(0, 14'h2A5C);
    wait_dones(0, d0, 1);
    vectors++;
    if (st_pulses[0] != p0 + 1 || oe_n[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_word_latch: got pulses %0d oe_n %b, want 1 and 0", st_pulses[0] - p0, oe_n[0]);
    end
  endtask

  task automatic test_lsb_div2;
    int p1, d1;
    p1 = st_pulses[1];
    d1 = done_cnt[1];
    accept_word(1, 14'h2A5C);
    wait_dones(1, d1, 1);
    vectors++;
    if (st_pulses[1] != p1 + 1) begin
      miscompares++;
      $display("FAIL lsb_div2_latch: got pulses %0d, want 1", st_pulses[1] - p1);
    end
  endtask

  task automatic test_back_to_back;
    int acc[3];
    int n_acc, d0, lat;
    n_acc = 0;
    d0    = done_cnt[0];
    lat   = DATA_W * DIV_A + DIV_A + 1;
    @(posedge sys_clk); #1;
    in_valid[0] = 1'b1;
    in_data[0]  = DATA_W'($urandom);
    for (int k = 0; k < 400 && n_acc < 3; k++) begin
      @(negedge sys_clk);
      if (in_ready[0]) begin
        note_accept(0);
        acc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge sys_clk); #1;
      if (n_acc == 3) in_valid[0] = 1'b0;
      in_data[0] = DATA_W'($urandom);
    end
    vectors++;
    if (n_acc != 3) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d, want 3", n_acc);
    end else begin
      for (int j = 1; j < 3; j++) begin
        vectors++;
        if (acc[j] - acc[j-1] != lat) begin
          miscompares++;
          $display("FAIL b2b_accept_gap%0d: got %0d, want %0d", j, acc[j] - acc[j-1], lat);
        end
      end
    end
    wait_dones(0, d0, 3);
    vectors++;
    if (st_rise[0] - st_rise_prev[0] != lat) begin
      miscompares++;
      $display("FAIL b2b_stcp_gap: got %0d, want %0d", st_rise[0] - st_rise_prev[0], lat);
    end
  endtask

  task automatic test_reset_mid;
    int p0, d0, k;
    p0 = st_pulses[0];
    accept_word(0, 14'h1F0F);
    for (k = 0; k < 200 && rise_cnt[0] < 6; k++) @(negedge sys_clk);
    vectors++;
    if (rise_cnt[0] < 6) begin
      miscompares++;
      $display("FAIL mid_reset_progress: got %0d rises, want 6", rise_cnt[0]);
    end
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    word_q0.delete();
    done_q0.delete();
    vectors++;
    if ({in_ready[0], ds[0], shcp[0], stcp[0], oe_n[0], done[0]} !== 6'b100010) begin
      miscompares++;
      $display("FAIL mid_reset_values: got %b, want 100010",
               {in_ready[0], ds[0], shcp[0], stcp[0], oe_n[0], done[0]});
    end
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (80) @(negedge sys_clk);
    vectors++;
    if (st_pulses[0] != p0 || oe_n[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_abort: got pulses %0d oe_n %b, want 0 and 1", st_pulses[0] - p0, oe_n[0]);
    end
    d0 = done_cnt[0];
    accept_word(0, 14'h3C96);
    wait_dones(0, d0, 1);
    vectors++;
    if (st_pulses[0] != p0 + 1 || oe_n[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_restart: got pulses %0d oe_n %b, want 1 and 0", st_pulses[0] - p0, oe_n[0]);
    end
  endtask

`ifdef HC595_PWM_EN
  task automatic test_pwm;
    int lows;
    bright = 8'd64;
    repeat (4) @(negedge sys_clk);
    lows = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge sys_clk);
      if (oe_n[0] === 1'b0) lows++;
    end
    vectors++;
    if (lows != 64) begin
      miscompares++;
      $display("FAIL pwm_64: got %0d low cycles, want 64", lows);
    end
    bright = 8'd0;
    repeat (4) @(negedge sys_clk);
    lows = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge sys_clk);
      if (oe_n[0] !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL pwm_0: got %0d low cycles, want 0", lows);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_word();
    test_lsb_div2();
    test_back_to_back();
    test_reset_mid();
`ifdef HC595_PWM_EN
    test_pwm();
`endif
    repeat (4) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
